// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline interlock: tracks in-flight register writers after DEC and drives
// per-stage load enables / NOP injection. Optional macro: HAZARD_FORWARDING_EN.
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES  = 6,
    parameter int HAZ_DEPTH   = 2,
    parameter int REG_AW      = 5,
    parameter int FLUSH_STAGE = 3,
    parameter int BUSY_STAGE  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_AW-1:0]     rs1_dec,
    input  logic [REG_AW-1:0]     rs2_dec,
    input  logic                  rs1_used_dec,
    input  logic                  rs2_used_dec,
    input  logic [REG_AW-1:0]     rd_dec,
    input  logic                  rd_used_dec,
    input  logic                  rd_load_dec,
    input  logic                  flush_pipeline,
    input  logic                  busy,
    output logic [NUM_STAGES-1:0] stage_ena,
    output logic [NUM_STAGES-1:0] stage_nop,
    output logic [15:0]           stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              load;
    } sb_entry_t;

    // Entry k describes the instruction currently held in stage 2+k.
    sb_entry_t sb_q [HAZ_DEPTH];
    sb_entry_t sb_d [HAZ_DEPTH];
    sb_entry_t new_entry;

    logic [15:0]          stall_cnt_q, stall_cnt_d;
    logic [HAZ_DEPTH-1:0] match;
    logic                 hazard;
    logic                 hazard_stall;

    always_comb begin
        match = '0;
        for (int k = 0; k < HAZ_DEPTH; k++) begin
            match[k] = sb_q[k].valid && (sb_q[k].rd != '0) &&
                       ((rs1_used_dec && (rs1_dec == sb_q[k].rd)) ||
                        (rs2_used_dec && (rs2_dec == sb_q[k].rd)));
        end
`ifdef HAZARD_FORWARDING_EN
        // ALU results are forwarded; only a load directly ahead must bubble.
        hazard = match[0] && sb_q[0].load;
`else
        hazard = |match;
`endif
        // A stall is never raised while reset is held.
        hazard_stall = hazard && !reset;
    end

    always_comb begin
        stage_ena = '1;
        stage_nop = '0;
        if (flush_pipeline) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (i < FLUSH_STAGE) stage_nop[i] = 1'b1;
            end
        end else if (busy) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (i <= BUSY_STAGE) stage_ena[i] = 1'b0;
            end
            stage_nop[BUSY_STAGE+1] = 1'b1;
        end else if (hazard_stall) begin
            stage_ena[0] = 1'b0;
            stage_ena[1] = 1'b0;
            stage_nop[2] = 1'b1;
        end
    end

    always_comb begin
        new_entry.valid = rd_used_dec || rd_load_dec;
        new_entry.rd    = rd_dec;
        new_entry.load  = rd_load_dec;
        sb_d[0] = new_entry;
        for (int k = 1; k < HAZ_DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        stall_cnt_d = stall_cnt_q;
        if (flush_pipeline) begin
            for (int k = 0; k < HAZ_DEPTH; k++) begin
                if (k + 2 <= FLUSH_STAGE) sb_d[k].valid = 1'b0;
            end
        end else if (busy) begin
            // Stages up to BUSY_STAGE freeze; BUSY_STAGE+1 receives a bubble.
            for (int k = 0; k < HAZ_DEPTH; k++) begin
                if (k + 2 <= BUSY_STAGE)          sb_d[k] = sb_q[k];
                else if (k + 2 == BUSY_STAGE + 1) sb_d[k] = '0;
            end
        end else if (hazard_stall) begin
            sb_d[0] = '0;
            if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < HAZ_DEPTH; k++) sb_q[k] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < HAZ_DEPTH; k++) sb_q[k] <= sb_d[k];
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// all checked against a stage-occupancy model of the pipeline.
module tb_pipeline_hazard_ctrl;

  localparam int NS = 6;
  localparam int HD = 2;
  localparam int AW = 5;
  localparam int FS = 3;
  localparam int BS = 3;

  logic          clk;
  logic          reset;
  logic [AW-1:0] rs1_dec, rs2_dec, rd_dec;
  logic          rs1_used_dec, rs2_used_dec, rd_used_dec, rd_load_dec;
  logic          flush_pipeline, busy;
  logic [NS-1:0] stage_ena, stage_nop;
  logic [15:0]   stall_cnt;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Model: what each pipeline stage (2..NS-1) holds, as a register writer.
  logic          m_valid [NS];
  logic [AW-1:0] m_rd    [NS];
  logic          m_load  [NS];
  logic [15:0]   m_cnt;

  pipeline_hazard_ctrl #(
    .NUM_STAGES(NS), .HAZ_DEPTH(HD), .REG_AW(AW),
    .FLUSH_STAGE(FS), .BUSY_STAGE(BS)
  ) dut (
    .clk(clk), .reset(reset),
    .rs1_dec(rs1_dec), .rs2_dec(rs2_dec),
    .rs1_used_dec(rs1_used_dec), .rs2_used_dec(rs2_used_dec),
    .rd_dec(rd_dec), .rd_used_dec(rd_used_dec), .rd_load_dec(rd_load_dec),
    .flush_pipeline(flush_pipeline), .busy(busy),
    .stage_ena(stage_ena), .stage_nop(stage_nop), .stall_cnt(stall_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver + reference model ----------------
  // Called in the low clock phase: applies inputs, checks, advances the model,
  // and returns at the next falling edge.
  task automatic drive(input logic [AW-1:0] r1, input logic u1,
                       input logic [AW-1:0] r2, input logic u2,
                       input logic [AW-1:0] rd, input logic ru, input logic rl,
                       input logic fl, input logic bz, input logic rst);
    logic          hz;
    logic [NS-1:0] e_ena, e_nop;
    rs1_dec = r1; rs1_used_dec = u1;
    rs2_dec = r2; rs2_used_dec = u2;
    rd_dec = rd; rd_used_dec = ru; rd_load_dec = rl;
    flush_pipeline = fl; busy = bz; reset = rst;
    #1;
    hz = 1'b0;
    for (int s = 2; s < 2 + HD; s++) begin
      if (m_valid[s] && m_rd[s] != 0 && ((u1 && r1 == m_rd[s]) || (u2 && r2 == m_rd[s]))) begin
`ifdef HAZARD_FORWARDING_EN
        if (s == 2 && m_load[s]) hz = 1'b1;
`else
        hz = 1'b1;
`endif
      end
    end
    if (rst) hz = 1'b0;
    e_ena = '1;
    e_nop = '0;
    if (fl) begin
      for (int i = 0; i < FS; i++) e_nop[i] = 1'b1;
    end else if (bz) begin
      for (int i = 0; i <= BS; i++) e_ena[i] = 1'b0;
      e_nop[BS+1] = 1'b1;
    end else if (hz) begin
      e_ena[1:0] = 2'b00;
      e_nop[2] = 1'b1;
    end
    check_eq("stage_ena", 32'(stage_ena), 32'(e_ena));
    check_eq("stage_nop", 32'(stage_nop), 32'(e_nop));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    // Advance the pipeline picture by one clock.
    if (rst) begin
      for (int s = 0; s < NS; s++) m_valid[s] = 1'b0;
      m_cnt = '0;
    end else if (fl || (!bz && !hz)) begin
      for (int s = NS - 1; s > 2; s--) begin
        m_valid[s] = m_valid[s-1]; m_rd[s] = m_rd[s-1]; m_load[s] = m_load[s-1];
      end
      m_valid[2] = ru || rl; m_rd[2] = rd; m_load[2] = rl;
      if (fl) for (int s = 0; s <= FS; s++) m_valid[s] = 1'b0;
    end else if (bz) begin
      for (int s = NS - 1; s > BS + 1; s--) begin
        m_valid[s] = m_valid[s-1]; m_rd[s] = m_rd[s-1]; m_load[s] = m_load[s-1];
      end
      m_valid[BS+1] = 1'b0;
    end else begin
      for (int s = NS - 1; s > 2; s--) begin
        m_valid[s] = m_valid[s-1]; m_rd[s] = m_rd[s-1]; m_load[s] = m_load[s-1];
      end
      m_valid[2] = 1'b0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rst);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, rst);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = 1'b0; m_rd[s] = '0; m_load[s] = 1'b0;
    end
    m_cnt = '0;
    reset = 1'b1;
    rs1_dec = '0; rs2_dec = '0; rd_dec = '0;
    rs1_used_dec = 0; rs2_used_dec = 0; rd_used_dec = 0; rd_load_dec = 0;
    flush_pipeline = 0; busy = 0;
    @(negedge clk);
    idle(1);
    idle(1);
    check_eq("reset_cnt", 32'(stall_cnt), 32'd0);

    // Write x5 then read x5.
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(5, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    drive(5, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    drive(5, 1, 0, 0, 9, 1, 0, 0, 0, 0);
`ifndef HAZARD_FORWARDING_EN
    check_eq("dep_stall_cnt", 32'(stall_cnt), 32'd2);
`endif
    idle(0);

    // x0 never stalls.
    idle(1);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    check_eq("x0_cnt", 32'(stall_cnt), 32'd0);

`ifdef HAZARD_FORWARDING_EN
    // ALU result forwarded, load needs one bubble.
    idle(1);
    drive(0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    drive(7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("fwd_alu_cnt", 32'(stall_cnt), 32'd0);
    drive(0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    drive(0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    check_eq("fwd_load_cnt", 32'(stall_cnt), 32'd1);
`endif

    // Flush while a hazard is pending.
    idle(1);
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    check_eq("flush_nop", 32'(stage_nop), 32'h07);
    check_eq("flush_ena", 32'(stage_ena), 32'h3F);
    drive(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("post_flush_nop", 32'(stage_nop), 32'h00);

    // Busy for three cycles.
    idle(1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2, 1, 3, 1, 0, 0, 1, 0);
      check_eq("busy_ena", 32'(stage_ena), 32'h30);
      check_eq("busy_nop", 32'(stage_nop), 32'h10);
    end
    drive(1, 1, 2, 1, 3, 1, 0, 0, 0, 0);

    // Counter saturation.
    idle(1);
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
      drive(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    idle(0);
    check_eq("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    idle(1);
    check_eq("sat_reset_cnt", 32'(stall_cnt), 32'd0);

    // Random traffic over a small register range to force overlaps.
    for (int n = 0; n < 400; n++) begin
      drive(AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
